// File: rtl/jam_gen.sv
// Exhaustive assignment search: walks every permutation of N jobs over N workers in
// lexicographic order, refetching only the changed suffix, and reports best total and tie count.
module jam_gen #(
    parameter int unsigned N  = 8,
    parameter int unsigned CW = 7,
    parameter int unsigned MW = 16
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            START,
    input  logic            MODE,
    output logic [2:0]      W,
    output logic [2:0]      J,
    input  logic [CW-1:0]   Cost,
    output logic [CW+2:0]   BestCost,
    output logic [MW-1:0]   MatchCount,
    output logic            Valid,
    output logic            Busy
);

    typedef enum logic [2:0] {
        StIdle, StFetch, StCmp, StPivot, StMaxSite, StSwap, StRev, StOut
    } state_e;

    localparam logic [2:0] LastIdx = 3'(N - 1);

    state_e          state_q, state_d;
    logic [2:0]      p_q [N];
    logic [2:0]      p_d [N];
    logic [CW-1:0]   c_q [N];
    logic [CW-1:0]   c_d [N];
    logic [2:0]      idx_q, idx_d;
    logic [2:0]      piv_q, piv_d;
    logic [2:0]      sel_q, sel_d;
    logic            have_q, have_d;
    logic            first_q, first_d;
    logic            mode_q, mode_d;
    logic [CW+2:0]   best_q, best_d;
    logic [MW-1:0]   cnt_q, cnt_d;
    logic            valid_q, valid_d;
    logic            busy_q, busy_d;

    logic [CW+2:0]   total;
    logic            desc;
    logic            better;

    always_comb begin
        total = '0;
        desc  = 1'b1;
        for (int w = 0; w < N; w++) begin
            total = total + {3'b000, c_q[w]};
            if (p_q[w] != 3'(N - 1 - w)) desc = 1'b0;
        end
        better = mode_q ? (total > best_q) : (total < best_q);
    end

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        c_d     = c_q;
        idx_d   = idx_q;
        piv_d   = piv_q;
        sel_d   = sel_q;
        have_d  = have_q;
        first_d = first_q;
        mode_d  = mode_q;
        best_d  = best_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (START) begin
                    state_d = StFetch;
                    mode_d  = MODE;
                    first_d = 1'b1;
                    idx_d   = 3'd0;
                    for (int w = 0; w < N; w++) p_d[w] = 3'(w);
                end
            end
            StFetch: begin
                c_d[idx_q] = Cost;
                if (idx_q == LastIdx) state_d = StCmp;
                else                  idx_d   = idx_q + 3'd1;
            end
            StCmp: begin
                if (first_q || better) begin
                    best_d = total;
                    cnt_d  = MW'(1);
                end else if (total == best_q) begin
                    cnt_d = cnt_q + MW'(1);
                end
                first_d = 1'b0;
                idx_d   = LastIdx - 3'd1;
                state_d = desc ? StOut : StPivot;
            end
            StPivot: begin
                if (p_q[idx_q] < p_q[idx_q + 3'd1]) begin
                    piv_d   = idx_q;
                    idx_d   = LastIdx;
                    have_d  = 1'b0;
                    state_d = StMaxSite;
                end else begin
                    idx_d = idx_q - 3'd1;
                end
            end
            StMaxSite: begin
                // Keep the smallest element of the suffix that still exceeds the pivot value.
                if (p_q[idx_q] > p_q[piv_q] && (!have_q || p_q[idx_q] < p_q[sel_q])) begin
                    sel_d  = idx_q;
                    have_d = 1'b1;
                end
                if (idx_q == piv_q + 3'd1) state_d = StSwap;
                else                       idx_d   = idx_q - 3'd1;
            end
            StSwap: begin
                p_d[piv_q] = p_q[sel_q];
                p_d[sel_q] = p_q[piv_q];
                state_d    = StRev;
            end
            StRev: begin
                for (int w = 0; w < N; w++) begin
                    if (3'(w) > piv_q) p_d[w] = p_q[3'(N - 1 - w) + piv_q + 3'd1];
                end
                idx_d   = piv_q;
                state_d = StFetch;
            end
            StOut: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        valid_d = (state_d == StOut);
        busy_d  = (state_d != StIdle);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= StIdle;
            for (int w = 0; w < N; w++) begin
                p_q[w] <= 3'(w);
                c_q[w] <= '0;
            end
            idx_q   <= '0;
            piv_q   <= '0;
            sel_q   <= '0;
            have_q  <= 1'b0;
            first_q <= 1'b0;
            mode_q  <= 1'b0;
            best_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            c_q     <= c_d;
            idx_q   <= idx_d;
            piv_q   <= piv_d;
            sel_q   <= sel_d;
            have_q  <= have_d;
            first_q <= first_d;
            mode_q  <= mode_d;
            best_q  <= best_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign W          = (state_q == StFetch) ? idx_q : 3'd0;
    assign J          = (state_q == StFetch) ? p_q[idx_q] : 3'd0;
    assign BestCost   = best_q;
    assign MatchCount = cnt_q;
    assign Valid      = valid_q;
    assign Busy       = busy_q;

endmodule

// File: tb/tb_jam_gen.sv
// Directed bench: three jam_gen instances (N=2,3,4) share START/MODE/reset, each with its own
// cost table; results and the N=4 fetch order are compared against hand-computed values.
module tb_jam_gen;

    logic clk = 1'b0;
    logic rst_n, start, mode, uniform;
    always #5 clk = ~clk;

    logic [2:0] w2, j2, w3, j3, w4, j4;
    logic [6:0] c2, c3, c4;
    logic [9:0] b2, b3, b4;
    logic [15:0] m2, m3, m4;
    logic v2, v3, v4, y2, y3, y4;
    logic [6:0] tbl [4][4];

    assign c2 = 7'(w2 * 2 + j2);
    assign c3 = (w3 == j3) ? 7'd10 : 7'd1;
    assign c4 = uniform ? 7'd5 : tbl[w4[1:0]][j4[1:0]];

    jam_gen #(.N(2)) u2 (.CLK(clk), .RST_N(rst_n), .START(start), .MODE(mode), .W(w2), .J(j2),
        .Cost(c2), .BestCost(b2), .MatchCount(m2), .Valid(v2), .Busy(y2));
    jam_gen #(.N(3)) u3 (.CLK(clk), .RST_N(rst_n), .START(start), .MODE(mode), .W(w3), .J(j3),
        .Cost(c3), .BestCost(b3), .MatchCount(m3), .Valid(v3), .Busy(y3));
    jam_gen #(.N(4)) u4 (.CLK(clk), .RST_N(rst_n), .START(start), .MODE(mode), .W(w4), .J(j4),
        .Cost(c4), .BestCost(b4), .MatchCount(m4), .Valid(v4), .Busy(y4));

    int ncomp = 0;
    int nfail = 0;
    int vc2 = 0, vc3 = 0, vc4 = 0;

    always @(negedge clk) begin
        if (v2) vc2++;
        if (v3) vc3++;
        if (v4) vc4++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic m);
        @(negedge clk);
        start = 1'b1;
        mode  = m;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((y2 || y3 || y4) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("%s timeout", tag), 32'(n < 3000), 32'd1);
    endtask

    task automatic check_results(input string tag, input int s2, input int s3, input int s4,
                                 input int eb2, input int em2, input int eb3, input int em3,
                                 input int eb4, input int em4);
        check($sformatf("%s valid2", tag), 32'(vc2 - s2), 32'd1);
        check($sformatf("%s valid3", tag), 32'(vc3 - s3), 32'd1);
        check($sformatf("%s valid4", tag), 32'(vc4 - s4), 32'd1);
        check($sformatf("%s best2", tag), 32'(b2), 32'(eb2));
        check($sformatf("%s cnt2", tag), 32'(m2), 32'(em2));
        check($sformatf("%s best3", tag), 32'(b3), 32'(eb3));
        check($sformatf("%s cnt3", tag), 32'(m3), 32'(em3));
        check($sformatf("%s best4", tag), 32'(b4), 32'(eb4));
        check($sformatf("%s cnt4", tag), 32'(m4), 32'(em4));
    endtask

    task automatic run(input logic m, input string tag, input int eb2, input int em2,
                       input int eb3, input int em3, input int eb4, input int em4);
        int s2 = vc2;
        int s3 = vc3;
        int s4 = vc4;
        pulse_start(m);
        wait_idle(tag);
        check_results(tag, s2, s3, s4, eb2, em2, eb3, em3, eb4, em4);
    endtask

    // Fetch order for the first three permutations of N=4: full fetch, then suffix refetches.
    int exp_w [21] = '{0, 1, 2, 3, 0, 0, 0, 0, 0, 2, 3, 0, 0, 0, 0, 0, 0, 0, 1, 2, 3};
    int exp_j [21] = '{0, 1, 2, 3, 0, 0, 0, 0, 0, 3, 2, 0, 0, 0, 0, 0, 0, 0, 2, 1, 3};

    initial begin
        int s2, s3, s4;
        tbl[0] = '{7'd3, 7'd7, 7'd1, 7'd9};
        tbl[1] = '{7'd2, 7'd8, 7'd6, 7'd4};
        tbl[2] = '{7'd5, 7'd1, 7'd9, 7'd7};
        tbl[3] = '{7'd8, 7'd3, 7'd2, 7'd6};
        uniform = 1'b0;
        rst_n   = 1'b0;
        start   = 1'b0;
        mode    = 1'b0;

        #1;
        check("rst busy", 32'(y4), 32'd0);
        check("rst valid", 32'(v4), 32'd0);
        check("rst best", 32'(b4), 32'd0);
        check("rst cnt", 32'(m4), 32'd0);
        check("rst wj", 32'({w4, j4}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("no autostart", 32'({y2, y3, y4}), 32'd0);

        // N=4 table run with per-cycle W/J fetch trace.
        s2 = vc2; s3 = vc3; s4 = vc4;
        pulse_start(1'b0);
        check("busy after start", 32'(y4), 32'd1);
        for (int i = 0; i < 21; i++) begin
            check($sformatf("fetch cyc%0d", i + 1), 32'({w4, j4}),
                  32'({3'(exp_w[i]), 3'(exp_j[i])}));
            @(negedge clk);
        end
        wait_idle("min");
        check_results("min", s2, s3, s4, 3, 2, 3, 2, 10, 2);

        run(1'b1, "max", 3, 2, 30, 1, 34, 1);

        uniform = 1'b1;
        run(1'b0, "uniform", 3, 2, 3, 2, 20, 24);
        uniform = 1'b0;

        // START and MODE toggled while busy must not disturb the minimum search.
        s2 = vc2; s3 = vc3; s4 = vc4;
        pulse_start(1'b0);
        @(negedge clk);
        start = 1'b1;
        mode  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("glitch");
        check_results("glitch", s2, s3, s4, 3, 2, 3, 2, 10, 2);

        // Asynchronous reset mid-search.
        s4 = vc4;
        pulse_start(1'b0);
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort busy", 32'(y4), 32'd0);
        check("abort best", 32'(b4), 32'd0);
        check("abort cnt", 32'(m4), 32'd0);
        check("abort wj", 32'({w4, j4}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("abort no valid", 32'(vc4 - s4), 32'd0);
        check("abort idle", 32'({y2, y3, y4}), 32'd0);
        run(1'b0, "fresh", 3, 2, 3, 2, 10, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule
